// File: rtl/ram6_reverse_lookup.sv
// Five-entry value table searched sequentially for a key; reports the lowest
// matching entry as a thermometer code. Writes are addressed by thermometer code too.
module ram6_reverse_lookup #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [3:0]        wr_code,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic [DATA_W-1:0] key,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [3:0]        code,
   output logic              wr_err
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] table_q [DEPTH];
   logic [DATA_W-1:0] key_q, key_d;
   logic [2:0]        idx_q, idx_d;
   logic              found_q, found_d;
   logic [3:0]        code_q, code_d;
   logic              wr_err_q;
   logic              wr_valid;
   logic [2:0]        wr_idx;
   logic              hit;

   function automatic logic [3:0] idx_to_code(input logic [2:0] idx);
      case (idx)
         3'd0:    idx_to_code = 4'b0000;
         3'd1:    idx_to_code = 4'b0001;
         3'd2:    idx_to_code = 4'b0011;
         3'd3:    idx_to_code = 4'b0111;
         default: idx_to_code = 4'b1111;
      endcase
   endfunction

   always_comb begin
      wr_valid = 1'b1;
      wr_idx   = 3'd0;
      case (wr_code)
         4'b0000: wr_idx = 3'd0;
         4'b0001: wr_idx = 3'd1;
         4'b0011: wr_idx = 3'd2;
         4'b0111: wr_idx = 3'd3;
         4'b1111: wr_idx = 3'd4;
         default: wr_valid = 1'b0;
      endcase
   end

   // Compare reads the registered table, so a same-edge write is seen only next cycle
   assign hit = (table_q[idx_q] == key_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         table_q[0] <= DATA_W'(97243000);
         table_q[1] <= DATA_W'(98243000);
         table_q[2] <= DATA_W'(99243000);
         table_q[3] <= DATA_W'(243000);
         table_q[4] <= DATA_W'(1243000);
         wr_err_q   <= 1'b0;
      end else begin
         if (wr_en && wr_valid) table_q[wr_idx] <= wr_data;
         wr_err_q <= wr_en && !wr_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= 3'd0;
         found_q <= 1'b0;
         code_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         found_q <= found_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      found_d = found_q;
      code_d  = code_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               key_d   = key;
               idx_d   = 3'd0;
            end
         end
         SCAN: begin
            if (hit) begin
               state_d = DONE;
               found_d = 1'b1;
               code_d  = idx_to_code(idx_q);
            end else if (idx_q == 3'd4) begin
               state_d = DONE;
               found_d = 1'b0;
               code_d  = 4'b0000;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != IDLE);
      done   = (state_q == DONE);
      found  = found_q;
      code   = code_q;
      wr_err = wr_err_q;
   end

endmodule

// File: tb/tb_ram6_reverse_lookup.sv
// Bench for ram6_reverse_lookup: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural table model.
module tb_ram6_reverse_lookup;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [3:0]        wr_code = 4'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              start = 1'b0;
   logic [DATA_W-1:0] key = '0;
   logic              busy, done, found, wr_err;
   logic [3:0]        code;

   int vectors = 0;
   int errors  = 0;

   // Behavioural model: table contents plus an in-flight search cursor
   logic [DATA_W-1:0] m_tab [5];
   int                m_phase;   // 0 idle, 1 searching, 2 reporting
   int                m_pos;
   logic [DATA_W-1:0] m_key;
   logic              m_found, m_err;
   logic [3:0]        m_code;

   ram6_reverse_lookup #(.DATA_W(DATA_W), .DEPTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_code(wr_code), .wr_data(wr_data),
      .start(start), .key(key), .busy(busy), .done(done), .found(found),
      .code(code), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] thermo(input int i);
      return 4'((1 << i) - 1);
   endfunction

   function automatic int code_index(input logic [3:0] c);
      for (int i = 0; i < 5; i++) if (c == thermo(i)) return i;
      return -1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_tab[0] = 97243000; m_tab[1] = 98243000; m_tab[2] = 99243000;
      m_tab[3] = 243000;   m_tab[4] = 1243000;
      m_phase = 0; m_pos = 0; m_key = '0;
      m_found = 1'b0; m_code = 4'b0; m_err = 1'b0;
   endtask

   // Advance one clock: update the model from the inputs seen at the edge, then compare
   task automatic step();
      int nphase;
      int widx;
      @(posedge clk);
      nphase = m_phase;
      widx   = code_index(wr_code);
      if (m_phase == 0) begin
         if (start) begin nphase = 1; m_pos = 0; m_key = key; end
      end else if (m_phase == 1) begin
         if (m_tab[m_pos] == m_key) begin
            nphase = 2; m_found = 1'b1; m_code = thermo(m_pos);
         end else if (m_pos == 4) begin
            nphase = 2; m_found = 1'b0; m_code = 4'b0;
         end else begin
            m_pos++;
         end
      end else begin
         nphase = 0;
      end
      m_err = wr_en && (widx < 0);
      if (wr_en && widx >= 0) m_tab[widx] = wr_data;
      m_phase = nphase;
      #1;
      check("cycle {busy,done,found,code,wr_err}",
            {24'b0, busy, done, found, code, wr_err},
            {24'b0, m_phase != 0, m_phase == 2, m_found, m_code, m_err});
   endtask

   task automatic do_write(input logic [3:0] c, input logic [DATA_W-1:0] d, input logic exp_err);
      wr_en = 1'b1; wr_code = c; wr_data = d;
      step();
      wr_en = 1'b0;
      check("wr_err pulse", wr_err, exp_err);
      step();
      check("wr_err cleared", wr_err, 1'b0);
   endtask

   // Start a search; n is the number of edges after the start edge until done shows
   task automatic run_search(input logic [DATA_W-1:0] k, input int n, input logic exp_f,
                             input logic [3:0] exp_c, input logic hold);
      int first = -1;
      int pulses = 0;
      logic f_at = 1'b0;
      logic [3:0] c_at = 4'b0;
      logic busy_after = 1'b1;
      start = 1'b1; key = k;
      step();
      for (int e = 1; e <= 12; e++) begin
         start = hold && (e <= n + 1);
         step();
         if (done) begin
            pulses++;
            if (first < 0) begin first = e; f_at = found; c_at = code; end
         end
         if (first >= 0 && e == first + 1) busy_after = busy;
      end
      start = 1'b0;
      check("done latency", first, n);
      check("done pulse count", pulses, 1);
      check("found", f_at, exp_f);
      check("code", c_at, exp_c);
      check("busy after done", busy_after, 1'b0);
   endtask

   task automatic apply_reset(input logic start_on_release);
      #2 rst_n = 1'b0;
      #1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset found", found, 1'b0);
      check("reset code", code, 4'b0);
      check("reset wr_err", wr_err, 1'b0);
      model_reset();
      wr_en = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      start = start_on_release;
   endtask

   logic [DATA_W-1:0] pool [8];

   initial begin
      int pulses;
      model_reset();
      pool[0] = 97243000; pool[1] = 98243000; pool[2] = 99243000; pool[3] = 243000;
      pool[4] = 1243000;  pool[5] = 12345;    pool[6] = 7;        pool[7] = 5;

      @(posedge clk); #1;
      apply_reset(1'b0);

      run_search(97243000, 1, 1'b1, 4'b0000, 1'b0);
      run_search(1243000, 5, 1'b1, 4'b1111, 1'b0);
      run_search(5, 5, 1'b0, 4'b0000, 1'b0);

      do_write(4'b0011, 12345, 1'b0);
      run_search(12345, 3, 1'b1, 4'b0011, 1'b0);
      run_search(99243000, 5, 1'b0, 4'b0000, 1'b0);

      do_write(4'b0101, 7, 1'b1);
      run_search(7, 5, 1'b0, 4'b0000, 1'b0);
      run_search(243000, 4, 1'b1, 4'b0111, 1'b0);

      run_search(1243000, 5, 1'b1, 4'b1111, 1'b1);
      do_write(4'b0000, 98243000, 1'b0);
      do_write(4'b0001, 98243000, 1'b0);
      run_search(98243000, 1, 1'b1, 4'b0000, 1'b0);

      // Same-edge write and compare of entry 0: the old value is what gets compared
      start = 1'b1; key = 42;
      step();
      start = 1'b0; wr_en = 1'b1; wr_code = 4'b0000; wr_data = 42;
      step();
      wr_en = 1'b0;
      repeat (5) step();
      check("pre-write compare found", found, 1'b0);
      run_search(42, 1, 1'b1, 4'b0000, 1'b0);

      // Reset in the middle of a scan aborts it without a done pulse
      start = 1'b1; key = 5;
      step();
      start = 1'b0;
      step();
      step();
      apply_reset(1'b0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin step(); if (done) pulses++; end
      check("no done after abort", pulses, 0);
      run_search(99243000, 3, 1'b1, 4'b0011, 1'b0);
      run_search(98243000, 2, 1'b1, 4'b0001, 1'b0);
      run_search(97243000, 1, 1'b1, 4'b0000, 1'b0);

      // Start held across reset release is taken on the first edge
      apply_reset(1'b1);
      key = 243000;
      step();
      start = 1'b0;
      check("start after reset accepted", busy, 1'b1);
      repeat (6) step();

      for (int i = 0; i < 400; i++) begin
         wr_en   = ($urandom_range(0, 4) == 0);
         wr_code = ($urandom_range(0, 1) == 0) ? thermo($urandom_range(0, 4))
                                               : 4'($urandom_range(0, 15));
         wr_data = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
         start   = ($urandom_range(0, 2) == 0);
         key     = pool[$urandom_range(0, 7)];
         step();
      end
      wr_en = 1'b0; start = 1'b0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/ram6_reverse_lookup.md
RAM6_REVERSE_LOOKUP -- requirements
Module: ram6_reverse_lookup

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the table entry and key width.
REQ-002 SHALL have parameter DEPTH, default 5, giving the number of table entries; only 5 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port wr_en, input, 1 bit: table write request.
REQ-006 SHALL have port wr_code, input, 4 bits: thermometer index of the entry to write.
REQ-007 SHALL have port wr_data, input, DATA_W bits: value to write.
REQ-008 SHALL have port start, input, 1 bit: search request.
REQ-009 SHALL have port key, input, DATA_W bits: value to search for.
REQ-010 SHALL have port busy, output, 1 bit: search in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle search-complete pulse.
REQ-012 SHALL have port found, output, 1 bit: the last search matched an entry.
REQ-013 SHALL have port code, output, 4 bits: thermometer code of the matched entry.
REQ-014 SHALL have port wr_err, output, 1 bit: one-cycle invalid-write-code pulse.

Function
REQ-015 SHALL hold a 5-entry table indexed 0..4, with the thermometer codes 0000, 0001, 0011, 0111 and 1111 respectively.
REQ-016 SHALL perform a write on the rising edge when wr_en=1 and wr_code is a valid code; the write is accepted in any FSM state.
REQ-017 SHALL, on wr_en=1 with an invalid wr_code, leave the table unchanged and assert wr_err for exactly the next cycle.
REQ-018 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-019 SHALL accept start only in IDLE: capture key, set the scan index to 0 and go to SCAN; start in SCAN or DONE SHALL be ignored.
REQ-020 SHALL compare one entry per cycle in SCAN, against the captured key.
REQ-021 SHALL move to DONE on a match; if there is no match, the index SHALL increment, and if index 4 does not match the FSM SHALL also move to DONE.
REQ-022 SHALL, with multiple matching entries, report the lowest index.
REQ-023 SHALL have latency: start sampled at edge T; a match at index i gives done=1 in the cycle after edge T+1+i; no match gives done in the cycle after edge T+5.
REQ-024 SHALL, in DONE, assert done for one cycle, update found and code (code=0000 when found=0), and return to IDLE.
REQ-025 SHALL hold found and code stable until the next DONE.
REQ-026 SHALL assert busy in the SCAN and DONE states.
REQ-027 SHALL, on a same-edge write and compare of the same entry, compare the pre-write value; the written value SHALL be visible from the following cycle.
REQ-028 SHALL use the full DATA_W-bit equality compare, with no masking.

Reset
REQ-029 SHALL, on rst_n=0, immediately force IDLE and set busy=0, done=0, found=0, code=0000 and wr_err=0.
REQ-030 SHALL, on reset, load the table with 97243000, 98243000, 99243000, 243000 and 1243000 (decimal) at indices 0..4.
REQ-031 SHALL, on reset asserted mid-scan, abort the scan with no done pulse; start SHALL be accepted on the first edge after rst_n rises.

Verification
REQ-032 SHALL cover: reset, then key=97243000 with start at edge T -> done at T+2, found=1, code=0000, busy low after the done cycle.
REQ-033 SHALL cover: key=1243000 -> done at T+6, found=1, code=1111; then key=5 -> done at T+6, found=0, code=0000.
REQ-034 SHALL cover: write code 0011 with data 12345, then search 12345 -> done at T+4, found=1, code=0011; search 99243000 -> found=0.
REQ-035 SHALL cover: write code 0101 with data 7 -> wr_err pulses 1 cycle, table unchanged; a search for 7 -> found=0.
REQ-036 SHALL cover: start asserted while busy -> ignored, exactly one done pulse; write entry 1 to 98243000 while entry 0 is also 98243000 -> code=0000.
REQ-037 SHALL cover: rst_n low during SCAN -> busy=0 asynchronously, no done pulse, table restored to the reset values.
